// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and the {pc, inst} buffer entry for the fetch stage
`ifndef MEM_LEN
`define MEM_LEN 64
`endif
`ifndef INST_SIZE
`define INST_SIZE 32
`endif
package fetch_pkg;
  localparam int ADDR_W = $clog2(`MEM_LEN);
  typedef struct packed {
    logic [ADDR_W-1:0]     pc;
    logic [`INST_SIZE-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: flushable FIFO with a registered head; level port exists only with FETCH_PERF_EN
module fetch_fifo import fetch_pkg::*; #(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
`ifdef FETCH_PERF_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);
  localparam int PW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [PW-1:0] rptr, wptr, hidx;
  logic [PW:0] cnt, rem;
  assign full  = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rem   = cnt - (PW+1)'(pop);
  assign hidx  = rptr + PW'(pop);
`ifdef FETCH_PERF_EN
  assign level = cnt;
`endif
  // storage, pointers and a head register that holds its value while empty
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      rptr <= '0;
      wptr <= '0;
      head <= '0;
    end else if (flush) begin
      cnt  <= '0;
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= hidx;
      cnt <= rem + (PW+1)'(push);
      if (rem != '0) head <= mem[hidx];
      else if (push) head <= din;
    end
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC owner feeding decode through a fetch buffer; FETCH_PERF_EN adds perf counters
module inst_fetch_unit import fetch_pkg::*; #(
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  output logic [ADDR_W-1:0]     inst_addr,
  input  logic [`INST_SIZE-1:0] inst,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [`INST_SIZE-1:0] out_inst,
  output logic [ADDR_W-1:0]     out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_flushed
`endif
);
  logic [ADDR_W-1:0] pc;
  logic full, empty, pop, push;
  fetch_entry_t head;
  assign pop       = ~empty & out_ready;
  assign push      = fetch_en & ~redirect_valid & (~full | pop);
  assign inst_addr = pc;
  assign out_valid = ~empty;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
`ifdef FETCH_PERF_EN
  logic [$clog2(FIFO_DEPTH):0] level;
`endif
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .din  ('{pc: pc, inst: inst}),
    .full (full),
    .empty(empty),
    .head (head)
`ifdef FETCH_PERF_EN
    ,
    .level(level)
`endif
  );
  // PC: redirect overrides sequential advance; holds when nothing is pushed
  always_ff @(posedge clk) begin
    pc <= rst ? RESET_PC : redirect_valid ? redirect_pc : push ? pc + 1'b1 : pc;
  end
`ifdef FETCH_PERF_EN
  // pushes and entries thrown away by redirects (the same-cycle pop is not lost)
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid) perf_flushed <= perf_flushed + 32'(level) - 32'(pop);
    end
  end
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: randomized and directed checks of inst_fetch_unit against a queue model
`ifndef MEM_LEN
`define MEM_LEN 64
`endif
`ifndef INST_SIZE
`define INST_SIZE 32
`endif
module tb_inst_fetch_unit;
  localparam int AW    = $clog2(`MEM_LEN);
  localparam int IW    = `INST_SIZE;
  localparam int DEPTH = 2;
  localparam int VW    = 1 + AW + IW + AW;
  typedef struct { logic [AW-1:0] pc; logic [IW-1:0] inst; } ent_t;

  logic clk = 0, rst = 1, fetch_en = 0, redirect_valid = 0, out_ready = 0;
  logic [AW-1:0] redirect_pc = '0, inst_addr, out_pc;
  logic [IW-1:0] inst, out_inst;
  logic out_valid;
  logic [IW-1:0] imem [`MEM_LEN];
  assign inst = imem[inst_addr];
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  inst_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .inst_addr(inst_addr), .inst(inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  ent_t q[$];
  logic [AW-1:0] m_pc = '0, l_pc = '0;
  logic [IW-1:0] l_inst = '0;
  logic [31:0] m_fetched = 0, m_flushed = 0;

  function automatic logic [VW-1:0] exp_vec();
    return {q.size() != 0, l_pc, l_inst, m_pc};
  endfunction

  // advance one clock, applying the fetch rules to the queue model at the edge
  task automatic tick();
    bit pop, push;
    pop  = q.size() != 0 && out_ready;
    push = fetch_en && !redirect_valid && (q.size() < DEPTH || pop);
    @(posedge clk);
    if (rst) begin
      q.delete(); m_pc = '0; l_pc = '0; l_inst = '0; m_fetched = 0; m_flushed = 0;
    end else if (redirect_valid) begin
      m_flushed += 32'(q.size()) - 32'(pop);
      q.delete(); m_pc = redirect_pc;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{m_pc, imem[m_pc]});
        m_pc = m_pc + 1'b1;
        m_fetched++;
      end
    end
    if (q.size() != 0) begin l_pc = q[0].pc; l_inst = q[0].inst; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick();
    tests++;
    if ({out_valid, out_pc, out_inst, inst_addr} !== {1'b0, {AW{1'b0}}, {IW{1'b0}}, {AW{1'b0}}}) begin
      fails++;
      $display("FAIL reset: got %h want %h", {out_valid, out_pc, out_inst, inst_addr}, exp_vec());
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < `MEM_LEN; i++) imem[i] = IW'(i);
    rst = 0; fetch_en = 1; out_ready = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_pc !== AW'(k-1) || out_inst !== IW'(k-1) ||
          {out_valid, out_pc, out_inst, inst_addr} !== exp_vec()) begin
        fails++;
        $display("FAIL stream k=%0d: got v=%b pc=%h inst=%h addr=%h want %h", k, out_valid, out_pc, out_inst, inst_addr, exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 0;
    for (int k = 0; k < 9; k++) begin
      if (k == 5) out_ready = 1;
      tick();
      tests++;
      if ({out_valid, out_pc, out_inst, inst_addr} !== exp_vec()) begin
        fails++;
        $display("FAIL stall k=%0d: got %h want %h", k, {out_valid, out_pc, out_inst, inst_addr}, exp_vec());
      end
    end
  endtask

  task automatic test_redirect();
    logic [AW-1:0] want_pc;
    out_ready = 0; tick(); tick();
    out_ready = 1; redirect_valid = 1; redirect_pc = AW'(16);
    tick();
    redirect_valid = 0;
    tests++;
    if (out_valid !== 1'b0 || inst_addr !== AW'(16)) begin
      fails++;
      $display("FAIL redirect_flush: got v=%b addr=%h want v=0 addr=10", out_valid, inst_addr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      want_pc = AW'(16 + k);
      tests++;
      if (out_valid !== 1'b1 || out_pc !== want_pc || {out_valid, out_pc, out_inst, inst_addr} !== exp_vec()) begin
        fails++;
        $display("FAIL redirect_seq k=%0d: got pc=%h v=%b want pc=%h", k, out_pc, out_valid, want_pc);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < `MEM_LEN; i++) imem[i] = $urandom;
    redirect_valid = 1; redirect_pc = AW'(`MEM_LEN - 2); tick(); redirect_valid = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if ({out_valid, out_pc, out_inst, inst_addr} !== exp_vec()) begin
        fails++;
        $display("FAIL wrap k=%0d: got %h want %h", k, {out_valid, out_pc, out_inst, inst_addr}, exp_vec());
      end
    end
  endtask

  task automatic test_halt();
    out_ready = 0; tick(); tick();
    fetch_en = 0; out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) fetch_en = 1;
      tick();
      tests++;
      if ({out_valid, out_pc, out_inst, inst_addr} !== exp_vec()) begin
        fails++;
        $display("FAIL halt k=%0d: got %h want %h", k, {out_valid, out_pc, out_inst, inst_addr}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 0; tick(); tick(); tick();
    out_ready = 1; rst = 1; redirect_valid = 1; redirect_pc = AW'(5);
    tick();
    rst = 0; redirect_valid = 0;
    tests++;
    if (out_valid !== 1'b0 || inst_addr !== {AW{1'b0}}) begin
      fails++;
      $display("FAIL reset_mid: got v=%b addr=%h want v=0 addr=0", out_valid, inst_addr);
    end
`ifdef FETCH_PERF_EN
    tests++;
    if ({perf_fetched, perf_flushed} !== 64'd0) begin
      fails++;
      $display("FAIL reset_perf: got %h %h want 0 0", perf_fetched, perf_flushed);
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      rst            = $urandom_range(0, 60) == 0;
      fetch_en       = $urandom_range(0, 3) != 0;
      out_ready      = $urandom_range(0, 2) != 0;
      redirect_valid = $urandom_range(0, 7) == 0;
      redirect_pc    = AW'($urandom);
      tick();
      tests++;
      if ({out_valid, out_pc, out_inst, inst_addr} !== exp_vec()) begin
        fails++;
        $display("FAIL random k=%0d: got %h want %h", k, {out_valid, out_pc, out_inst, inst_addr}, exp_vec());
      end
`ifdef FETCH_PERF_EN
      tests++;
      if ({perf_fetched, perf_flushed} !== {m_fetched, m_flushed}) begin
        fails++;
        $display("FAIL random_perf k=%0d: got %0d %0d want %0d %0d", k, perf_fetched, perf_flushed, m_fetched, m_flushed);
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < `MEM_LEN; i++) imem[i] = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
